// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the MIPS pipeline register slice.
//   NOP_INSTR         - instruction word used for bubbles (sll $0,$0,0)
//   DEFAULT_RESET_PC  - fetch address after reset
//   stage_bundle_t    - {instr, pc8, valid} carried by every inter-stage register
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          NUM_STAGES       = 4;  // IF/ID, ID/EX, EX/MEM, MEM/WB

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        valid;
  } stage_bundle_t;

  // Bubble decodes as no class in the hazard unit: no forwarding, no stall.
  localparam stage_bundle_t STAGE_BUBBLE = '{instr: NOP_INSTR, pc8: 32'h0, valid: 1'b0};

endpackage

// File: rtl/pipe_regs_if.sv
// pipe_regs_if: groups the hazard-unit controls, fetch inputs and per-stage
// outputs of pipe_regs.
//   slave  - pipe_regs side (consumes controls, drives stage outputs)
//   master - hazard unit / fetch side
// With PIPE_PERF_EN defined the interface also carries the performance
// counters cycle_cnt, stall_cnt and retire_cnt.
interface pipe_regs_if;
  logic        PC_EN;
  logic        IFID_EN;
  logic        IDEX_CLR;
  logic [31:0] NPC;
  logic [31:0] InstrF;
  logic        movzE;

  logic [31:0] PC;
  logic [31:0] InstructionD, InstructionE, InstructionM, InstructionW;
  logic [31:0] PC8D, PC8E, PC8M, PC8W;
  logic        validD, validE, validM, validW;
  logic        movzM, movzW;
`ifdef PIPE_PERF_EN
  logic [31:0] cycle_cnt, stall_cnt, retire_cnt;
`endif

  modport slave (
    input  PC_EN, IFID_EN, IDEX_CLR, NPC, InstrF, movzE,
    output PC,
    output InstructionD, InstructionE, InstructionM, InstructionW,
    output PC8D, PC8E, PC8M, PC8W,
    output validD, validE, validM, validW,
    output movzM, movzW
`ifdef PIPE_PERF_EN
    , output cycle_cnt, stall_cnt, retire_cnt
`endif
  );

  modport master (
    output PC_EN, IFID_EN, IDEX_CLR, NPC, InstrF, movzE,
    input  PC,
    input  InstructionD, InstructionE, InstructionM, InstructionW,
    input  PC8D, PC8E, PC8M, PC8W,
    input  validD, validE, validM, validW,
    input  movzM, movzW
`ifdef PIPE_PERF_EN
    , input cycle_cnt, stall_cnt, retire_cnt
`endif
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one inter-stage register holding a stage_bundle_t.
//   clk, reset - rising-edge clock, async active-high reset (loads bubble)
//   en         - load d (0 = hold)
//   clr        - load bubble; wins over en
//   d, q       - stage bundle in / out
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  stage_bundle_t d,
  output stage_bundle_t q
);

  stage_bundle_t q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q_q <= STAGE_BUBBLE;
    else if (clr) q_q <= STAGE_BUBBLE;
    else if (en)  q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_regs.sv
// pipe_regs: PC register plus IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - pipe_regs_if.slave: PC_EN / IFID_EN / IDEX_CLR from the hazard
//            unit, NPC, InstrF, movzE in; PC, Instruction*/PC8*/valid*,
//            movzM/movzW out (all outputs are flops)
// Optional macro PIPE_PERF_EN adds cycle/stall/retire counters.
module pipe_regs
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  pipe_regs_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic        movzm_q, movzw_q;

  stage_bundle_t [NUM_STAGES-1:0] stg_d, stg_q;
  logic          [NUM_STAGES-1:0] stg_en, stg_clr;

  // PC
  assign pc_d = bus.PC_EN ? bus.NPC : pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // Stage 0 captures the fetch; later stages shift the previous one.
  // PC+8 wraps at 32 bits.
  always_comb begin
    stg_d[0] = '{instr: bus.InstrF, pc8: pc_q + 32'd8, valid: 1'b1};
    for (int s = 1; s < NUM_STAGES; s++) stg_d[s] = stg_q[s-1];
  end

  // Only IF/ID can hold, only ID/EX can be flushed; M and W always advance.
  assign stg_en  = {1'b1, 1'b1, 1'b1, bus.IFID_EN};
  assign stg_clr = {1'b0, 1'b0, bus.IDEX_CLR, 1'b0};

  generate
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      pipe_stage_reg u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (stg_en[s]),
        .clr   (stg_clr[s]),
        .d     (stg_d[s]),
        .q     (stg_q[s])
      );
    end
  endgenerate

  // movz condition is only meaningful for a real instruction in E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      movzm_q <= 1'b0;
      movzw_q <= 1'b0;
    end else begin
      movzm_q <= bus.movzE & stg_q[1].valid;
      movzw_q <= movzm_q;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.InstructionD = stg_q[0].instr;
  assign bus.InstructionE = stg_q[1].instr;
  assign bus.InstructionM = stg_q[2].instr;
  assign bus.InstructionW = stg_q[3].instr;
  assign bus.PC8D         = stg_q[0].pc8;
  assign bus.PC8E         = stg_q[1].pc8;
  assign bus.PC8M         = stg_q[2].pc8;
  assign bus.PC8W         = stg_q[3].pc8;
  assign bus.validD       = stg_q[0].valid;
  assign bus.validE       = stg_q[1].valid;
  assign bus.validM       = stg_q[2].valid;
  assign bus.validW       = stg_q[3].valid;
  assign bus.movzM        = movzm_q;
  assign bus.movzW        = movzw_q;

`ifdef PIPE_PERF_EN
  logic [31:0] cycle_q, stall_q, retire_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      if (bus.IDEX_CLR)   stall_q  <= stall_q + 32'd1;
      if (stg_q[3].valid) retire_q <= retire_q + 32'd1;
    end
  end

  assign bus.cycle_cnt  = cycle_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: directed + randomized bench for pipe_regs against a
// stage-list reference model.
module tb_pipe_regs;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_regs_if bus ();

  pipe_regs #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        valid;
  } mstage_t;

  // model: slot 0 = D, 1 = E, 2 = M, 3 = W
  mstage_t     ms [4];
  logic [31:0] mpc;
  logic        mmz_m, mmz_w;
  int unsigned mcyc, mstall, mretire;

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ms[i] = '{32'h0, 32'h0, 1'b0};
    mpc = 32'h0000_3000;
    mmz_m = 1'b0; mmz_w = 1'b0;
    mcyc = 0; mstall = 0; mretire = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".PC"},     bus.PC,           mpc);
    chk({ph, ".InstrD"}, bus.InstructionD, ms[0].instr);
    chk({ph, ".InstrE"}, bus.InstructionE, ms[1].instr);
    chk({ph, ".InstrM"}, bus.InstructionM, ms[2].instr);
    chk({ph, ".InstrW"}, bus.InstructionW, ms[3].instr);
    chk({ph, ".PC8D"},   bus.PC8D,         ms[0].pc8);
    chk({ph, ".PC8E"},   bus.PC8E,         ms[1].pc8);
    chk({ph, ".PC8M"},   bus.PC8M,         ms[2].pc8);
    chk({ph, ".PC8W"},   bus.PC8W,         ms[3].pc8);
    chk({ph, ".valid"},  {28'h0, bus.validW, bus.validM, bus.validE, bus.validD},
        {28'h0, ms[3].valid, ms[2].valid, ms[1].valid, ms[0].valid});
    chk({ph, ".movz"},   {30'h0, bus.movzW, bus.movzM}, {30'h0, mmz_w, mmz_m});
`ifdef PIPE_PERF_EN
    chk({ph, ".cycle_cnt"},  bus.cycle_cnt,  mcyc);
    chk({ph, ".stall_cnt"},  bus.stall_cnt,  mstall);
    chk({ph, ".retire_cnt"}, bus.retire_cnt, mretire);
`endif
  endtask

  task automatic drv(input logic pe, input logic ie, input logic clr,
                     input logic [31:0] npc, input logic [31:0] instr, input logic mz);
    bus.PC_EN = pe; bus.IFID_EN = ie; bus.IDEX_CLR = clr;
    bus.NPC = npc; bus.InstrF = instr; bus.movzE = mz;
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare.
  task automatic tick(input string ph);
    @(posedge clk);
    if (!reset) begin
      mcyc++;
      if (bus.IDEX_CLR) mstall++;
      if (ms[3].valid)  mretire++;
      mmz_w = mmz_m;
      mmz_m = bus.movzE & ms[1].valid;
      ms[3] = ms[2];
      ms[2] = ms[1];
      ms[1] = bus.IDEX_CLR ? '{32'h0, 32'h0, 1'b0} : ms[0];
      if (bus.IFID_EN) ms[0] = '{bus.InstrF, mpc + 32'd8, 1'b1};
      if (bus.PC_EN)   mpc = bus.NPC;
    end
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] sv_pc, sv_d;

  initial begin
    reset = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 32'h0, 32'h8C08_0000, 1'b0);
    model_reset();
    #3;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // run a bit, then reset mid-operation with a load word on InstrF
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h8C08_0000, 1'b0);
      tick("pre");
    end
    #1;
    do_reset();
    chk("rst.PC_const", bus.PC, 32'h0000_3000);
    chk("rst.validD_const", {31'h0, bus.validD}, 32'h0);

    // free run: first fetch after reset is at 0x3000
    drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h2008_0005, 1'b0);
    tick("free");
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h0100_0000 + i, 1'b0);
      tick("free");
    end
    chk("free.InstrW_const", bus.InstructionW, 32'h2008_0005);
    chk("free.PC8W_const",   bus.PC8W,         32'h0000_3008);

    // load-use stall
    sv_pc = bus.PC; sv_d = bus.InstructionD;
    drv(1'b0, 1'b0, 1'b1, 32'hDEAD_0000, 32'h1111_1111, 1'b0);
    tick("stall");
    chk("stall.PC_hold",  bus.PC,           sv_pc);
    chk("stall.D_hold",   bus.InstructionD, sv_d);
    chk("stall.E_bubble", bus.InstructionE, 32'h0);
    chk("stall.validE",   {31'h0, bus.validE}, 32'h0);
    drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h2222_2222, 1'b0);
    tick("unstall");
    chk("unstall.E", bus.InstructionE, sv_d);

    // movz with a real instruction in E
    drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h0000_000A, 1'b1);
    tick("movz");
    chk("movz.M", {31'h0, bus.movzM}, 32'h1);
    drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h3333_3333, 1'b0);
    tick("movz");
    chk("movz.W", {31'h0, bus.movzW}, 32'h1);
    // movz condition with a bubble in E is dropped
    drv(1'b0, 1'b0, 1'b1, mpc, 32'h4444_4444, 1'b0);
    tick("mzb");
    drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'h5555_5555, 1'b1);
    tick("mzb");
    chk("movz.bubble", {31'h0, bus.movzM}, 32'h0);

    // IFID_EN with IDEX_CLR: D loads, E still bubbles
    drv(1'b1, 1'b1, 1'b1, mpc + 32'd4, 32'h6666_6666, 1'b0);
    tick("both");

    // PC wrap on PC+8
    drv(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h7777_7777, 1'b0);
    tick("wrap");
    drv(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h8888_8888, 1'b0);
    tick("wrap");
    chk("wrap.PC8D_const", bus.PC8D, 32'h0000_0004);

    // counters over 10 cycles with 2 stalls
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 5 || i == 7) drv(1'b0, 1'b0, 1'b1, mpc, 32'h9999_0000, 1'b0);
      else                  drv(1'b1, 1'b1, 1'b0, mpc + 32'd4, 32'hA000_0000 + i, 1'b0);
      tick("perf");
    end
`ifdef PIPE_PERF_EN
    chk("perf.cycle_const", bus.cycle_cnt, 32'd10);
    chk("perf.stall_const", bus.stall_cnt, 32'd2);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] npc;
      npc = ($urandom_range(0, 3) != 0) ? mpc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 31) == 0) npc = 32'hFFFF_FFFC;
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          npc, $urandom(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 63) == 0) begin
        #1;
        do_reset();
      end else begin
        tick("rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_regs.md
# pipe_regs

Program counter and inter-stage pipeline registers for the five-stage MIPS core. Holds PC, then carries each instruction word, its PC+8 link value and a valid bit through IF/ID, ID/EX, EX/MEM and MEM/WB. Also carries the resolved movz condition into MEM and WB. It consumes the hazard unit's PC_EN, IFID_EN and IDEX_CLR, and feeds the hazard unit's InstructionD/E/M/W, movzM and movzW inputs.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- PC_EN  input  1  PC update enable from hazard unit (0 = hold).
- IFID_EN  input  1  IF/ID update enable (0 = hold).
- IDEX_CLR  input  1  load bubble into ID/EX.
- NPC  input  32  next PC, from branch/jump select logic.
- InstrF  input  32  instruction fetched at PC.
- movzE  input  1  EX-stage movz write condition: movz and rt value == 0.
- PC  output  32  current fetch address.
- InstructionD, InstructionE, InstructionM, InstructionW  output  32 each  per-stage instruction word.
- PC8D, PC8E, PC8M, PC8W  output  32 each  per-stage PC+8 link value.
- validD, validE, validM, validW  output  1 each  stage holds a real instruction, not a bubble.
- movzM, movzW  output  1 each  movz condition, registered into MEM and WB.

## Operation
- **PC:** PC <= NPC when PC_EN = 1; otherwise PC holds.
- **IF/ID:** when IFID_EN = 1, loads {InstrF, PC+8, valid = 1}; otherwise holds.
- **ID/EX:**
  - IDEX_CLR = 1: loads bubble {32'h0, 32'h0, valid = 0}. Clear has priority over any other event.
  - IDEX_CLR = 0: loads the D-stage contents.
- **EX/MEM:** advances every cycle. movzM <= movzE & validE.
- **MEM/WB:** advances every cycle. movzW <= movzM.
- **Bubble encoding:** the instruction word 32'h0 (sll $0,$0,0) decodes as no class in the hazard decoder, so it produces no forwarding and no stall.
- **Simultaneous events:**
  - Normal stall is PC_EN = 0, IFID_EN = 0, IDEX_CLR = 1: D holds, E gets a bubble, M and W advance.
  - IFID_EN = 1 with IDEX_CLR = 1: D loads new, E still gets the bubble.
  - PC_EN and IFID_EN are independent; no cross-check is performed.
- **Arithmetic:** PC+8 is a 32-bit add with wrap-around; carry out is discarded (32'hFFFF_FFFC + 8 = 32'h0000_0004).

## Timing
- **Reset values:** all outputs clear asynchronously on reset assertion.
  - PC = RESET_PC.
  - All InstructionX = 0, PC8X = 0, validX = 0, movzM = movzW = 0.
- **Latency:** an instruction fetched in cycle n is
  - in D at n+1,
  - in E at n+2,
  - in M at n+3,
  - in W at n+4.
  - Each stall cycle adds one cycle per stall to the E, M and W arrivals.
- **Reset mid-operation:** all in-flight instructions are discarded. The first fetch after deassertion uses RESET_PC at the first rising edge.
- There are no combinational paths from inputs to outputs; every output is a flop.

## Configuration
- Macro: PIPE_PERF_EN.
- **Defined:**
  - Adds outputs cycle_cnt, stall_cnt and retire_cnt (32 bits each, reset to 0, wrap modulo 2^32).
  - cycle_cnt increments every cycle.
  - stall_cnt increments when IDEX_CLR = 1.
  - retire_cnt increments when validW = 1.
- **Undefined:** the ports and counters are absent; the module is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR = 32'h0 and DEFAULT_RESET_PC = 32'h0000_3000;
  - stage_bundle_t {instr[31:0], pc8[31:0], valid}.
- Sub-module pipe_stage_reg:
  - ports: clk, reset, en, clr, d, q, carrying one stage_bundle_t;
  - clr has priority over en;
  - instantiated four times, with the PC as a separate register;
  - EX/MEM and MEM/WB tie en = 1 and clr = 0.

## Test plan
- **Reset:** assert reset mid-run with InstrF = 32'h8C08_0000 -> next cycle PC = 32'h3000, all InstructionX = 0, all validX = 0.
- **Free run:** PC_EN = IFID_EN = 1, IDEX_CLR = 0, NPC = PC+4, InstrF = 32'h2008_0005 at PC 32'h3000 -> InstructionW = 32'h2008_0005 and PC8W = 32'h3008 exactly 4 cycles later.
- **Load-use stall:** one cycle of PC_EN = IFID_EN = 0, IDEX_CLR = 1 -> PC and InstructionD hold; InstructionE = 0 with validE = 0; the D instruction enters E the following cycle.
- **movz:** movz in E with movzE = 1 -> movzM = 1 next cycle, movzW = 1 the cycle after. A bubble in E with movzE = 1 -> movzM = 0.
- **PC wrap:** PC = 32'hFFFF_FFFC fetch -> PC8D = 32'h0000_0004.
- **PIPE_PERF_EN:** 10 cycles with 2 stalls and 5 retirements -> cycle_cnt = 10, stall_cnt = 2, retire_cnt = 5.
